pc_source_unit: RTL and testbench

- Parametrised successor to the combinational PC-source multiplexer, with the PC register folded in.
- Selects the next PC from NUM_SRC candidates, e.g. PC+4, ALU result, ALUOut, jump target, exception vector.
- Loads the PC on unconditional or branch-conditional write.
- Holds one pending redirect while the pipeline is stalled.
- Sits between the ALU/shift datapath and the instruction-memory address port; driven by the control unit.

---
 rtl/pc_source_pkg.sv | 22 ++
 rtl/pc_source_mux_n.sv | 27 ++
 rtl/pc_source_unit.sv | 119 +++++++++++
 tb/tb_pc_source_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_source_pkg.sv
// rtl/pc_source_pkg.sv - shared state encoding, defaults and source indices for the PC source unit
package pc_source_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } pc_state_t;

  localparam logic [31:0] PC_RESET_VECTOR_DEFAULT = 32'h0000_0000;

  localparam int SRC_PC4    = 0;
  localparam int SRC_ALU    = 1;
  localparam int SRC_ALUOUT = 2;
  localparam int SRC_JUMP   = 3;
  localparam int SRC_EXC    = 4;

  // A 2-way select still needs one selector bit.
  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_source_mux_n.sv
// rtl/pc_source_mux_n.sv - combinational N-way WIDTH-bit select with in-range flag
module pc_source_mux_n
  import pc_source_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = sel_width(N)
) (
  input  logic [SEL_W-1:0]   i_sel,
  input  logic [N*WIDTH-1:0] i_src_flat,
  output logic [WIDTH-1:0]   o_target,
  output logic               o_sel_ok
);

  // Selector codes at or above N match no slot, leaving target zero and sel_ok low.
  always_comb begin
    o_target = '0;
    o_sel_ok = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_sel == SEL_W'(i)) begin
        o_target = i_src_flat[i*WIDTH +: WIDTH];
        o_sel_ok = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_source_unit.sv
// rtl/pc_source_unit.sv - PC register with N-way source select and one-deep stall redirect buffer
// Optional alignment check enabled by defining PC_SOURCE_ALIGN_CHECK_EN (adds align_err).
module pc_source_unit
  import pc_source_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               NUM_SRC      = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR_DEFAULT),
  localparam int              SEL_W        = sel_width(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC*WIDTH-1:0] src_flat,
  input  logic                     pc_write,
  input  logic                     pc_write_cond,
  input  logic                     cond_zero,
  input  logic                     stall,
  output logic [WIDTH-1:0]         pc,
  output logic                     pending,
  output logic                     sel_err
`ifdef PC_SOURCE_ALIGN_CHECK_EN
  ,
  output logic                     align_err
`endif
);

  pc_state_t        r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pc, w_pc_nxt;
  logic [WIDTH-1:0] r_buf, w_buf_nxt;
  logic             r_sel_err, w_sel_err_nxt;
  logic [WIDTH-1:0] w_target;
  logic             w_sel_ok;
  logic             w_load_req;
  logic             w_accept;
  logic             w_align_ok;
  logic             w_take;

  pc_source_mux_n #(
    .WIDTH (WIDTH),
    .N     (NUM_SRC),
    .SEL_W (SEL_W)
  ) u_mux (
    .i_sel      (sel),
    .i_src_flat (src_flat),
    .o_target   (w_target),
    .o_sel_ok   (w_sel_ok)
  );

  assign w_load_req = pc_write | (pc_write_cond & cond_zero);
  assign w_accept   = w_load_req & w_sel_ok;

`ifdef PC_SOURCE_ALIGN_CHECK_EN
  logic r_align_err;
  assign w_align_ok = (w_target[1:0] == 2'b00);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_align_err <= 1'b0;
    else          r_align_err <= r_align_err | (w_accept & ~w_align_ok);
  end
  assign align_err = r_align_err;
`else
  assign w_align_ok = 1'b1;
`endif

  assign w_take = w_accept & w_align_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_pc      <= RESET_VECTOR;
      r_buf     <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_buf     <= w_buf_nxt;
      r_sel_err <= w_sel_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_buf_nxt     = r_buf;
    w_sel_err_nxt = r_sel_err | (w_load_req & ~w_sel_ok);
    case (r_state)
      IDLE: begin
        if (w_take) begin
          if (stall) begin
            w_buf_nxt   = w_target;
            w_state_nxt = PEND;
          end else begin
            w_pc_nxt = w_target;
          end
        end
      end
      PEND: begin
        if (stall) begin
          if (w_take) w_buf_nxt = w_target;
        end else if (w_accept) begin
          // A fresh request beats the stale buffer; a suppressed one keeps the redirect pending.
          if (w_align_ok) begin
            w_pc_nxt    = w_target;
            w_state_nxt = IDLE;
          end
        end else begin
          w_pc_nxt    = r_buf;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign pc      = r_pc;
  assign pending = (r_state == PEND);
  assign sel_err = r_sel_err;

endmodule

// File: tb/tb_pc_source_unit.sv
// tb/tb_pc_source_unit.sv - self-checking bench: vector table, reset/align sequences, random vs model
module tb_pc_source_unit;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   sel = '0;
  logic [127:0] src_flat = '0;
  logic         pw = 1'b0, pwc = 1'b0, cz = 1'b0, st = 1'b0;
  logic [31:0]  a_pc, b_pc;
  logic         a_pend, b_pend, a_err, b_err;
`ifdef PC_SOURCE_ALIGN_CHECK_EN
  logic         a_aerr, b_aerr;
`endif

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_source_unit #(.WIDTH(32), .NUM_SRC(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .sel(sel), .src_flat(src_flat),
    .pc_write(pw), .pc_write_cond(pwc), .cond_zero(cz), .stall(st),
    .pc(a_pc), .pending(a_pend), .sel_err(a_err)
`ifdef PC_SOURCE_ALIGN_CHECK_EN
    , .align_err(a_aerr)
`endif
  );

  pc_source_unit #(.WIDTH(32), .NUM_SRC(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .sel(sel), .src_flat(src_flat[95:0]),
    .pc_write(pw), .pc_write_cond(pwc), .cond_zero(cz), .stall(st),
    .pc(b_pc), .pending(b_pend), .sel_err(b_err)
`ifdef PC_SOURCE_ALIGN_CHECK_EN
    , .align_err(b_aerr)
`endif
  );

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] s0, s1, s2, s3;
    logic        pw, pwc, cz, st;
    logic [31:0] a_pc;
    logic        a_pend;
    logic [31:0] b_pc;
    logic        b_pend;
    logic        b_err;
  } vec_t;

  vec_t vecs[15];

  // Reference model: index 0 is the 4-source unit, index 1 the 3-source unit.
  logic [31:0] m_pc[2], m_buf[2];
  bit          m_has[2], m_err[2], m_aerr[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] s, input logic [31:0] v0, v1, v2, v3,
                       input logic w, wc, z, stl);
    sel = s;
    src_flat = {v3, v2, v1, v0};
    pw = w; pwc = wc; cz = z; st = stl;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pc[d] = 32'h0; m_buf[d] = 32'h0; m_has[d] = 0; m_err[d] = 0; m_aerr[d] = 0;
    end
  endtask

  task automatic model_step(input int d, input int ns);
    logic [31:0] tgt;
    bit lr, ok, al;
    lr  = pw | (pwc & cz);
    ok  = int'(sel) < ns;
    tgt = ok ? src_flat[sel*32 +: 32] : 32'h0;
`ifdef PC_SOURCE_ALIGN_CHECK_EN
    al = (tgt[1:0] == 2'b00);
`else
    al = 1;
`endif
    if (lr && !ok) m_err[d] = 1;
    if (lr && ok && !al) m_aerr[d] = 1;
    if (!m_has[d]) begin
      if (lr && ok && al) begin
        if (st) begin m_has[d] = 1; m_buf[d] = tgt; end
        else m_pc[d] = tgt;
      end
    end else if (st) begin
      if (lr && ok && al) m_buf[d] = tgt;
    end else if (lr && ok) begin
      if (al) begin m_pc[d] = tgt; m_has[d] = 0; end
    end else begin
      m_pc[d] = m_buf[d];
      m_has[d] = 0;
    end
  endtask

  initial begin
    vecs[0]  = '{2'd2, 32'h0,   32'h0,   32'h40,  32'h0,   1'b1,1'b0,1'b0,1'b0, 32'h40,  1'b0, 32'h40,  1'b0, 1'b0};
    vecs[1]  = '{2'd1, 32'h0,   32'h100, 32'h0,   32'h0,   1'b0,1'b1,1'b0,1'b0, 32'h40,  1'b0, 32'h40,  1'b0, 1'b0};
    vecs[2]  = '{2'd1, 32'h0,   32'h100, 32'h0,   32'h0,   1'b0,1'b1,1'b1,1'b0, 32'h100, 1'b0, 32'h100, 1'b0, 1'b0};
    vecs[3]  = '{2'd0, 32'h200, 32'h0,   32'h0,   32'h0,   1'b1,1'b1,1'b1,1'b0, 32'h200, 1'b0, 32'h200, 1'b0, 1'b0};
    vecs[4]  = '{2'd0, 32'h8,   32'h0,   32'h0,   32'h0,   1'b1,1'b0,1'b0,1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 1'b0};
    vecs[5]  = '{2'd3, 32'h0,   32'h0,   32'h0,   32'hC,   1'b1,1'b0,1'b0,1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 1'b1};
    vecs[6]  = '{2'd0, 32'h0,   32'h0,   32'h0,   32'h0,   1'b0,1'b0,1'b0,1'b0, 32'hC,   1'b0, 32'h8,   1'b0, 1'b1};
    vecs[7]  = '{2'd1, 32'h0,   32'h20,  32'h0,   32'h0,   1'b1,1'b0,1'b0,1'b1, 32'hC,   1'b1, 32'h8,   1'b1, 1'b1};
    vecs[8]  = '{2'd0, 32'h44,  32'h0,   32'h0,   32'h0,   1'b1,1'b0,1'b0,1'b0, 32'h44,  1'b0, 32'h44,  1'b0, 1'b1};
    vecs[9]  = '{2'd0, 32'h0,   32'h0,   32'h0,   32'h0,   1'b0,1'b0,1'b0,1'b1, 32'h44,  1'b0, 32'h44,  1'b0, 1'b1};
    vecs[10] = '{2'd3, 32'h0,   32'h0,   32'h0,   32'h80,  1'b1,1'b0,1'b0,1'b0, 32'h80,  1'b0, 32'h44,  1'b0, 1'b1};
    vecs[11] = '{2'd1, 32'h0,   32'h104, 32'h0,   32'h0,   1'b1,1'b0,1'b0,1'b0, 32'h104, 1'b0, 32'h104, 1'b0, 1'b1};
    vecs[12] = '{2'd2, 32'h0,   32'h0,   32'h300, 32'h0,   1'b1,1'b0,1'b0,1'b1, 32'h104, 1'b1, 32'h104, 1'b1, 1'b1};
    vecs[13] = '{2'd3, 32'h0,   32'h0,   32'h0,   32'h400, 1'b1,1'b0,1'b0,1'b0, 32'h400, 1'b0, 32'h300, 1'b0, 1'b1};
    vecs[14] = '{2'd0, 32'h0,   32'h0,   32'h0,   32'h0,   1'b0,1'b0,1'b0,1'b0, 32'h400, 1'b0, 32'h300, 1'b0, 1'b1};

    @(posedge clk); #1;
    chk("reset a_pc", a_pc, 32'h0);
    chk("reset a_pending", 32'(a_pend), 32'h0);
    chk("reset a_sel_err", 32'(a_err), 32'h0);
    chk("reset b_pending", 32'(b_pend), 32'h0);
    @(negedge clk) reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].sel, vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3,
            vecs[i].pw, vecs[i].pwc, vecs[i].cz, vecs[i].st);
      @(posedge clk); #1;
      chk($sformatf("vec%0d a_pc", i), a_pc, vecs[i].a_pc);
      chk($sformatf("vec%0d a_pending", i), 32'(a_pend), 32'(vecs[i].a_pend));
      chk($sformatf("vec%0d a_sel_err", i), 32'(a_err), 32'h0);
      chk($sformatf("vec%0d b_pc", i), b_pc, vecs[i].b_pc);
      chk($sformatf("vec%0d b_pending", i), 32'(b_pend), 32'(vecs[i].b_pend));
      chk($sformatf("vec%0d b_sel_err", i), 32'(b_err), 32'(vecs[i].b_err));
    end

    // Asynchronous reset while a redirect is pending, checked before any clock edge.
    drive(2'd0, 32'h8, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("pre-reset a_pending", 32'(a_pend), 32'h1);
    drive(2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset a_pc", a_pc, 32'h0);
    chk("async reset a_pending", 32'(a_pend), 32'h0);
    chk("async reset b_sel_err", 32'(b_err), 32'h0);
    @(negedge clk) reset_n = 1'b1;

    drive(2'd0, 32'h42, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
`ifdef PC_SOURCE_ALIGN_CHECK_EN
    chk("misaligned a_pc", a_pc, 32'h0);
    chk("misaligned align_err", 32'(a_aerr), 32'h1);
`else
    chk("misaligned a_pc", a_pc, 32'h42);
`endif
    drive(2'd0, 32'h50, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("aligned after misaligned a_pc", a_pc, 32'h50);
`ifdef PC_SOURCE_ALIGN_CHECK_EN
    chk("align_err sticky", 32'(a_aerr), 32'h1);
`endif

    drive(2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    model_reset();

    for (int c = 0; c < 400; c++) begin
      logic [31:0] v[4];
      for (int k = 0; k < 4; k++) begin
        v[k] = $urandom;
        if ($urandom_range(0, 3) != 0) v[k][1:0] = 2'b00;
      end
      drive(2'($urandom_range(0, 3)), v[0], v[1], v[2], v[3],
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 4) < 2);
      model_step(0, 4);
      model_step(1, 3);
      @(posedge clk); #1;
      chk("rand a_pc", a_pc, m_pc[0]);
      chk("rand a_pending", 32'(a_pend), 32'(m_has[0]));
      chk("rand a_sel_err", 32'(a_err), 32'(m_err[0]));
      chk("rand b_pc", b_pc, m_pc[1]);
      chk("rand b_pending", 32'(b_pend), 32'(m_has[1]));
      chk("rand b_sel_err", 32'(b_err), 32'(m_err[1]));
`ifdef PC_SOURCE_ALIGN_CHECK_EN
      chk("rand a_align_err", 32'(a_aerr), 32'(m_aerr[0]));
      chk("rand b_align_err", 32'(b_aerr), 32'(m_aerr[1]));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
